// File: rtl/servo_seq_pkg.sv
// Shared state encoding, widths and |error| helper for the servo lock sequencer.
package servo_seq_pkg;

  localparam int STATE_W  = 3;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SWEEP  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // One extra bit so that -32768 maps to +32768 instead of wrapping.
  function automatic logic [SAMPLE_W:0] abs_err(input logic signed [SAMPLE_W-1:0] v);
    logic signed [SAMPLE_W:0] x;
    logic [SAMPLE_W:0] r;
    x = {v[SAMPLE_W-1], v};
    r = v[SAMPLE_W-1] ? -x : x;
    return r;
  endfunction

endpackage

// File: rtl/servo_sweep_gen.sv
// Triangle ramp between SWEEP_MIN and SWEEP_MAX; registered output, one-cycle latency,
// no backpressure: freeze holds value and direction, reload snaps to SWEEP_MIN going up.
module servo_sweep_gen
  import servo_seq_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] SWEEP_MIN = -16'sd32000,
  parameter logic signed [SAMPLE_W-1:0] SWEEP_MAX = 16'sd32000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       reload,
  input  logic                       freeze,
  input  logic [SAMPLE_W-1:0]        step,
  output logic signed [SAMPLE_W-1:0] sweep
);

  localparam logic signed [SAMPLE_W+1:0] MIN_X = {{2{SWEEP_MIN[SAMPLE_W-1]}}, SWEEP_MIN};
  localparam logic signed [SAMPLE_W+1:0] MAX_X = {{2{SWEEP_MAX[SAMPLE_W-1]}}, SWEEP_MAX};

  logic                       down;
  logic signed [SAMPLE_W+1:0] cur_x;
  logic signed [SAMPLE_W+1:0] step_x;
  logic signed [SAMPLE_W+1:0] up_x;
  logic signed [SAMPLE_W+1:0] dn_x;

  // Two guard bits so a full-scale step never wraps before the clamp compare.
  assign cur_x  = {{2{sweep[SAMPLE_W-1]}}, sweep};
  assign step_x = {2'b00, step};
  assign up_x   = cur_x + step_x;
  assign dn_x   = cur_x - step_x;

  always_ff @(posedge clk) begin
    if (!rst_n || reload) begin
      sweep <= SWEEP_MIN;
      down  <= 1'b0;
    end else if (!freeze) begin
      if (!down) begin
        if (up_x >= MAX_X) begin
          sweep <= SWEEP_MAX;
          down  <= 1'b1;
        end else begin
          sweep <= up_x[SAMPLE_W-1:0];
        end
      end else begin
        if (dn_x <= MIN_X) begin
          sweep <= SWEEP_MIN;
          down  <= 1'b0;
        end else begin
          sweep <= dn_x[SAMPLE_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/servo_lock_sequencer.sv
// Sweep/settle/lock sequencer for a servo loop; all outputs registered, one-cycle latency, no backpressure.
// Define SERVO_SEQ_FAULT_EN to latch FAULT once the relock count reaches MAX_RELOCKS.
module servo_lock_sequencer
  import servo_seq_pkg::*;
#(
  parameter logic signed [15:0] SWEEP_MIN    = -16'sd32000,
  parameter logic signed [15:0] SWEEP_MAX    = 16'sd32000,
  parameter int                 RAIL_TIMEOUT = 1000,
  parameter int                 MAX_RELOCKS  = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               enable_in,
  input  logic signed [15:0] e_in,
  input  logic [1:0]         railed_in,
  input  logic [15:0]        lock_thresh_in,
  input  logic [15:0]        settle_cycles_in,
  input  logic [15:0]        sweep_step_in,
  output logic               servo_on_out,
  output logic               hold_out,
  output logic signed [15:0] sweep_out,
  output logic [2:0]         state_out,
  output logic               locked_out,
  output logic [7:0]         relock_count_out
);

  localparam int RAIL_W = $clog2(RAIL_TIMEOUT + 1);

  if (SWEEP_MIN >= SWEEP_MAX || RAIL_TIMEOUT < 1 || MAX_RELOCKS < 1) begin : g_param_check
    $error("servo_lock_sequencer: invalid parameter set");
  end

  state_t            state;
  logic [CNT_W-1:0]  settle_cnt;
  logic [RAIL_W-1:0] rail_cnt;
  logic [7:0]        relock_cnt;

  logic              lock_det;
  logic              rail_hit;
  logic              to_fault;
  logic              reload;
  logic              freeze;
  logic [CNT_W:0]    settle_nxt;
  logic [RAIL_W-1:0] rail_nxt;
  logic [7:0]        relock_nxt;

  assign lock_det   = abs_err(e_in) < {1'b0, lock_thresh_in};
  assign settle_nxt = {1'b0, settle_cnt} + (CNT_W+1)'(1);
  assign rail_nxt   = rail_cnt + RAIL_W'(1);
  assign relock_nxt = (relock_cnt == 8'hFF) ? 8'hFF : relock_cnt + 8'd1;
  assign rail_hit   = (state == ST_LOCKED) && (railed_in != 2'b00) &&
                      (rail_nxt == RAIL_W'(RAIL_TIMEOUT));

`ifdef SERVO_SEQ_FAULT_EN
  assign to_fault = rail_hit && (32'(relock_nxt) >= MAX_RELOCKS);
`else
  assign to_fault = 1'b0;
`endif

  // Ramp only advances while sweeping with no lock candidate; it stays frozen
  // through SETTLE/LOCKED so a fallback resumes from the same point.
  assign reload = !enable_in || (state == ST_IDLE) || (state == ST_FAULT) || to_fault;
  assign freeze = !((state == ST_SWEEP) && !lock_det);

  servo_sweep_gen #(
    .SWEEP_MIN (SWEEP_MIN),
    .SWEEP_MAX (SWEEP_MAX)
  ) u_sweep (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .reload (reload),
    .freeze (freeze),
    .step   (sweep_step_in),
    .sweep  (sweep_out)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in || !enable_in) begin
      state        <= ST_IDLE;
      servo_on_out <= 1'b0;
      hold_out     <= 1'b0;
      locked_out   <= 1'b0;
      relock_cnt   <= 8'd0;
      settle_cnt   <= '0;
      rail_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state        <= ST_SWEEP;
          servo_on_out <= 1'b0;
          hold_out     <= 1'b0;
        end
        ST_SWEEP: begin
          if (lock_det) begin
            state        <= ST_SETTLE;
            servo_on_out <= 1'b1;
            settle_cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cycles_in == 16'd0) begin
            state      <= ST_LOCKED;
            locked_out <= 1'b1;
            rail_cnt   <= '0;
          end else if (!lock_det) begin
            state        <= ST_SWEEP;
            servo_on_out <= 1'b0;
          end else if (settle_nxt >= {1'b0, settle_cycles_in}) begin
            state      <= ST_LOCKED;
            locked_out <= 1'b1;
            rail_cnt   <= '0;
          end else begin
            settle_cnt <= settle_nxt[CNT_W-1:0];
          end
        end
        ST_LOCKED: begin
          if (rail_hit) begin
            state        <= to_fault ? ST_FAULT : ST_SWEEP;
            servo_on_out <= 1'b0;
            hold_out     <= 1'b0;
            locked_out   <= 1'b0;
            relock_cnt   <= relock_nxt;
            rail_cnt     <= '0;
          end else if (railed_in != 2'b00) begin
            hold_out <= 1'b1;
            rail_cnt <= rail_nxt;
          end else begin
            hold_out <= 1'b0;
            rail_cnt <= '0;
          end
        end
`ifdef SERVO_SEQ_FAULT_EN
        ST_FAULT: begin
          servo_on_out <= 1'b0;
          hold_out     <= 1'b0;
          locked_out   <= 1'b0;
        end
`endif
        default: begin
          state        <= ST_IDLE;
          servo_on_out <= 1'b0;
          hold_out     <= 1'b0;
          locked_out   <= 1'b0;
        end
      endcase
    end
  end

  assign state_out        = state;
  assign relock_count_out = relock_cnt;

endmodule

// File: tb/tb_servo_lock_sequencer.sv
// Self-checking bench for servo_lock_sequencer: vector table plus directed lock/relock/reset sequences.
module tb_servo_lock_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               enable;
  logic signed [15:0] e;
  logic [1:0]         railed;
  logic [15:0]        thresh;
  logic [15:0]        settle;
  logic [15:0]        step;
  logic               servo_on;
  logic               hold;
  logic signed [15:0] sweep;
  logic [2:0]         state;
  logic               locked;
  logic [7:0]         relock;

  servo_lock_sequencer #(
    .SWEEP_MIN    (-16'sd32000),
    .SWEEP_MAX    (16'sd32000),
    .RAIL_TIMEOUT (1000),
    .MAX_RELOCKS  (2)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .enable_in        (enable),
    .e_in             (e),
    .railed_in        (railed),
    .lock_thresh_in   (thresh),
    .settle_cycles_in (settle),
    .sweep_step_in    (step),
    .servo_on_out     (servo_on),
    .hold_out         (hold),
    .sweep_out        (sweep),
    .state_out        (state),
    .locked_out       (locked),
    .relock_count_out (relock)
  );

  typedef struct {
    logic [2:0]         st;
    logic               on;
    logic               hd;
    logic signed [15:0] sw;
    logic               lk;
    logic [7:0]         rc;
  } exp_t;

  typedef struct {
    logic               en;
    logic signed [15:0] ev;
    logic [1:0]         rl;
    logic [15:0]        thr;
    logic [15:0]        stl;
    logic [15:0]        stp;
    exp_t               ex;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  function automatic exp_t mk(input logic [2:0] st, input logic on, input logic hd,
                              input logic signed [15:0] sw, input logic lk, input logic [7:0] rc);
    exp_t r;
    r.st = st; r.on = on; r.hd = hd; r.sw = sw; r.lk = lk; r.rc = rc;
    return r;
  endfunction

  task automatic expect_next(input string nm, input exp_t ex);
    exp_q.push_back(ex);
    name_q.push_back(nm);
  endtask

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic en, input logic signed [15:0] ev, input logic [1:0] rl);
    exp_t  ex;
    string nm;
    enable = en;
    e      = ev;
    railed = rl;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (state !== ex.st || servo_on !== ex.on || hold !== ex.hd || sweep !== ex.sw ||
          locked !== ex.lk || relock !== ex.rc) begin
        failures++;
        $display("FAIL %s: got st=%0d on=%0b hold=%0b sweep=%0d lk=%0b rc=%0d; want st=%0d on=%0b hold=%0b sweep=%0d lk=%0b rc=%0d",
                 nm, state, servo_on, hold, sweep, locked, relock,
                 ex.st, ex.on, ex.hd, ex.sw, ex.lk, ex.rc);
      end
    end
  endtask

  vec_t vt[15];

  initial begin
    rst_n = 1'b0; enable = 1'b0; e = '0; railed = '0;
    thresh = '0; settle = 16'd10; step = 16'd1000;

    expect_next("reset", mk(3'd0, 0, 0, -16'sd32000, 0, 8'd0));
    cyc(1'b1, 16'sd0, 2'b00);
    rst_n = 1'b1;

    // en, e, railed, thresh, settle, step, expected
    vt[0]  = '{1'b1, 16'sd0,      2'b00, 16'd0,     16'd10, 16'd1000,  mk(3'd1, 0, 0, -16'sd32000, 0, 8'd0)};
    vt[1]  = '{1'b1, 16'sd0,      2'b00, 16'd0,     16'd10, 16'd1000,  mk(3'd1, 0, 0, -16'sd31000, 0, 8'd0)};
    vt[2]  = '{1'b1, 16'sd0,      2'b00, 16'd0,     16'd10, 16'd0,     mk(3'd1, 0, 0, -16'sd31000, 0, 8'd0)};
    vt[3]  = '{1'b1, 16'sd0,      2'b00, 16'd0,     16'd10, 16'd65535, mk(3'd1, 0, 0, 16'sd32000,  0, 8'd0)};
    vt[4]  = '{1'b1, 16'sd0,      2'b00, 16'd0,     16'd10, 16'd1000,  mk(3'd1, 0, 0, 16'sd31000,  0, 8'd0)};
    vt[5]  = '{1'b0, 16'sd0,      2'b00, 16'd0,     16'd10, 16'd1000,  mk(3'd0, 0, 0, -16'sd32000, 0, 8'd0)};
    vt[6]  = '{1'b1, 16'sd100,    2'b00, 16'd100,   16'd10, 16'd1000,  mk(3'd1, 0, 0, -16'sd32000, 0, 8'd0)};
    vt[7]  = '{1'b1, 16'sd100,    2'b11, 16'd100,   16'd10, 16'd1000,  mk(3'd1, 0, 0, -16'sd31000, 0, 8'd0)};
    vt[8]  = '{1'b1, -16'sd100,   2'b00, 16'd100,   16'd10, 16'd1000,  mk(3'd1, 0, 0, -16'sd30000, 0, 8'd0)};
    vt[9]  = '{1'b1, -16'sd32768, 2'b00, 16'd32768, 16'd10, 16'd1000,  mk(3'd1, 0, 0, -16'sd29000, 0, 8'd0)};
    vt[10] = '{1'b1, -16'sd32768, 2'b00, 16'd65535, 16'd10, 16'd1000,  mk(3'd2, 1, 0, -16'sd29000, 0, 8'd0)};
    vt[11] = '{1'b0, 16'sd0,      2'b00, 16'd65535, 16'd10, 16'd1000,  mk(3'd0, 0, 0, -16'sd32000, 0, 8'd0)};
    vt[12] = '{1'b1, 16'sd99,     2'b00, 16'd100,   16'd10, 16'd1000,  mk(3'd1, 0, 0, -16'sd32000, 0, 8'd0)};
    vt[13] = '{1'b1, 16'sd99,     2'b00, 16'd100,   16'd10, 16'd1000,  mk(3'd2, 1, 0, -16'sd32000, 0, 8'd0)};
    vt[14] = '{1'b0, 16'sd99,     2'b00, 16'd100,   16'd10, 16'd1000,  mk(3'd0, 0, 0, -16'sd32000, 0, 8'd0)};

    for (int i = 0; i < 15; i++) begin
      thresh = vt[i].thr;
      settle = vt[i].stl;
      step   = vt[i].stp;
      expect_next($sformatf("vec%0d", i), vt[i].ex);
      cyc(vt[i].en, vt[i].ev, vt[i].rl);
    end

    // Full triangle: exact clamp at both limits and reversal.
    thresh = 16'd0; step = 16'd1000; settle = 16'd10;
    expect_next("ramp_start", mk(3'd1, 0, 0, -16'sd32000, 0, 8'd0));
    cyc(1'b1, 16'sd0, 2'b00);
    for (int k = 1; k <= 129; k++) begin
      if (k == 64)  expect_next("ramp_top",      mk(3'd1, 0, 0, 16'sd32000,  0, 8'd0));
      if (k == 65)  expect_next("ramp_top_next", mk(3'd1, 0, 0, 16'sd31000,  0, 8'd0));
      if (k == 128) expect_next("ramp_bot",      mk(3'd1, 0, 0, -16'sd32000, 0, 8'd0));
      if (k == 129) expect_next("ramp_bot_next", mk(3'd1, 0, 0, -16'sd31000, 0, 8'd0));
      cyc(1'b1, 16'sd0, 2'b00);
    end
    expect_next("ramp_disable", mk(3'd0, 0, 0, -16'sd32000, 0, 8'd0));
    cyc(1'b0, 16'sd0, 2'b00);

    // Settle abort, ramp resume, then full settle to LOCKED.
    thresh = 16'd100;
    cyc(1'b1, 16'sd1000, 2'b00);
    cyc(1'b1, 16'sd1000, 2'b00);
    cyc(1'b1, 16'sd1000, 2'b00);
    expect_next("settle_enter", mk(3'd2, 1, 0, -16'sd30000, 0, 8'd0));
    cyc(1'b1, 16'sd50, 2'b00);
    expect_next("settle_abort", mk(3'd1, 0, 0, -16'sd30000, 0, 8'd0));
    cyc(1'b1, 16'sd200, 2'b00);
    expect_next("ramp_resume", mk(3'd1, 0, 0, -16'sd29000, 0, 8'd0));
    cyc(1'b1, 16'sd1000, 2'b00);
    expect_next("settle_enter2", mk(3'd2, 1, 0, -16'sd29000, 0, 8'd0));
    cyc(1'b1, 16'sd50, 2'b00);
    for (int k = 0; k < 8; k++) cyc(1'b1, 16'sd50, 2'b00);
    expect_next("settle_last", mk(3'd2, 1, 0, -16'sd29000, 0, 8'd0));
    cyc(1'b1, 16'sd50, 2'b00);
    expect_next("locked", mk(3'd3, 1, 0, -16'sd29000, 1, 8'd0));
    cyc(1'b1, 16'sd50, 2'b00);

    // Rail timeout boundary: 999 railed cycles hold, 1000 relock.
    for (int k = 0; k < 998; k++) cyc(1'b1, 16'sd1000, 2'b10);
    expect_next("rail_999", mk(3'd3, 1, 1, -16'sd29000, 1, 8'd0));
    cyc(1'b1, 16'sd1000, 2'b10);
    expect_next("rail_clear", mk(3'd3, 1, 0, -16'sd29000, 1, 8'd0));
    cyc(1'b1, 16'sd1000, 2'b00);
    for (int k = 0; k < 998; k++) cyc(1'b1, 16'sd1000, 2'b01);
    expect_next("rail_999b", mk(3'd3, 1, 1, -16'sd29000, 1, 8'd0));
    cyc(1'b1, 16'sd1000, 2'b01);
    expect_next("relock1", mk(3'd1, 0, 0, -16'sd29000, 0, 8'd1));
    cyc(1'b1, 16'sd1000, 2'b01);
    expect_next("rail_ignored", mk(3'd1, 0, 0, -16'sd28000, 0, 8'd1));
    cyc(1'b1, 16'sd1000, 2'b11);

    // Zero settle time, then second timeout.
    expect_next("settle0_enter", mk(3'd2, 1, 0, -16'sd28000, 0, 8'd1));
    cyc(1'b1, 16'sd50, 2'b00);
    settle = 16'd0;
    expect_next("settle0_lock", mk(3'd3, 1, 0, -16'sd28000, 1, 8'd1));
    cyc(1'b1, 16'sd50, 2'b00);
    for (int k = 0; k < 999; k++) cyc(1'b1, 16'sd1000, 2'b10);
`ifdef SERVO_SEQ_FAULT_EN
    expect_next("fault_enter", mk(3'd4, 0, 0, -16'sd32000, 0, 8'd2));
    cyc(1'b1, 16'sd1000, 2'b10);
    expect_next("fault_hold", mk(3'd4, 0, 0, -16'sd32000, 0, 8'd2));
    cyc(1'b1, 16'sd50, 2'b00);
`else
    expect_next("relock2", mk(3'd1, 0, 0, -16'sd28000, 0, 8'd2));
    cyc(1'b1, 16'sd1000, 2'b10);
    expect_next("relock2_ramp", mk(3'd1, 0, 0, -16'sd27000, 0, 8'd2));
    cyc(1'b1, 16'sd1000, 2'b00);
`endif
    expect_next("disable_clear", mk(3'd0, 0, 0, -16'sd32000, 0, 8'd0));
    cyc(1'b0, 16'sd1000, 2'b00);

    // Full-scale negative error locks; reset mid-LOCKED clears everything.
    thresh = 16'd65535; settle = 16'd0;
    expect_next("neg_sweep", mk(3'd1, 0, 0, -16'sd32000, 0, 8'd0));
    cyc(1'b1, -16'sd32768, 2'b00);
    expect_next("neg_settle", mk(3'd2, 1, 0, -16'sd32000, 0, 8'd0));
    cyc(1'b1, -16'sd32768, 2'b00);
    expect_next("neg_locked", mk(3'd3, 1, 0, -16'sd32000, 1, 8'd0));
    cyc(1'b1, -16'sd32768, 2'b00);
    expect_next("neg_hold", mk(3'd3, 1, 1, -16'sd32000, 1, 8'd0));
    cyc(1'b1, -16'sd32768, 2'b10);
    rst_n = 1'b0;
    expect_next("reset_locked", mk(3'd0, 0, 0, -16'sd32000, 0, 8'd0));
    cyc(1'b1, -16'sd32768, 2'b10);
    rst_n = 1'b1;
    cyc(1'b1, -16'sd32768, 2'b00);
    cyc(1'b1, -16'sd32768, 2'b00);
    expect_next("relock_after_reset", mk(3'd3, 1, 0, -16'sd32000, 1, 8'd0));
    cyc(1'b1, -16'sd32768, 2'b00);
    for (int k = 0; k < 998; k++) cyc(1'b1, -16'sd32768, 2'b10);
    expect_next("rail_cnt_reset", mk(3'd3, 1, 1, -16'sd32000, 1, 8'd0));
    cyc(1'b1, -16'sd32768, 2'b10);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
